// File: rtl/add_serial.sv
// add_serial: multi-cycle adder/subtractor, CHUNK bits per clock,
// carry rippled through a register, valid/ready on both sides.
module add_serial #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [CHUNK-1:0] ca;
   logic [CHUNK-1:0] cb;
   logic [CHUNK-1:0] cs;
   logic             cc;
   logic             accept;
   logic             last;

   assign ca   = opa[int'(idx)*CHUNK +: CHUNK];
   assign cb   = opb[int'(idx)*CHUNK +: CHUNK];
   assign last = (idx == LAST);
   assign sum  = acc;

   assign {cc, cs} = {1'b0, ca} + {1'b0, cb}
                   + {{CHUNK{1'b0}}, carry};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         acc   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         opa   <= a;
         opb   <= sub ? ~b : b;
         carry <= sub;
         idx   <= '0;
         acc   <= '0;
      end else if (state == RUN) begin
         acc[int'(idx)*CHUNK +: CHUNK] <= cs;
         carry <= cc;
         idx   <= idx + 1'b1;
         if (last) begin
            cout <= cc;
            ovf  <= (opa[WIDTH-1] == opb[WIDTH-1])
                 && (cs[CHUNK-1] != opa[WIDTH-1]);
         end
      end
   end

endmodule

// File: tb/tb_add_serial.sv
// tb_add_serial: randomized and directed checks of add_serial
// against a signed/unsigned arithmetic reference model.
module tb_add_serial;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // main instance: WIDTH=16, CHUNK=4
   logic        in_valid, out_ready, sub;
   logic [15:0] a, b;
   logic        in_ready, out_valid, cout, ovf;
   logic [15:0] sum;

   add_serial #(.WIDTH(16), .CHUNK(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   // variants: [0] WIDTH=32/CHUNK=8, [1] WIDTH=16/CHUNK=16
   logic [1:0]  v_in_valid, v_out_ready, v_sub;
   logic [31:0] v_a [2];
   logic [31:0] v_b [2];
   wire  [1:0]  v_in_ready, v_out_valid, v_cout, v_ovf;
   wire  [31:0] w_sum0;
   wire  [15:0] w_sum1;

   add_serial #(.WIDTH(32), .CHUNK(8)) dut32 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(v_in_valid[0]), .in_ready(v_in_ready[0]),
      .a(v_a[0]), .b(v_b[0]), .sub(v_sub[0]),
      .out_valid(v_out_valid[0]), .out_ready(v_out_ready[0]),
      .sum(w_sum0), .cout(v_cout[0]), .ovf(v_ovf[0])
   );

   add_serial #(.WIDTH(16), .CHUNK(16)) dut1c (
      .clock(clock), .reset_n(reset_n),
      .in_valid(v_in_valid[1]), .in_ready(v_in_ready[1]),
      .a(v_a[1][15:0]), .b(v_b[1][15:0]), .sub(v_sub[1]),
      .out_valid(v_out_valid[1]), .out_ready(v_out_ready[1]),
      .sum(w_sum1), .cout(v_cout[1]), .ovf(v_ovf[1])
   );

   logic [15:0] t_a [9] = '{16'h0000, 16'h0000, 16'hFFFF,
                            16'hAAAA, 16'h3CC3, 16'h1234,
                            16'h8000, 16'h0001, 16'h7FFF};
   logic [15:0] t_b [9] = '{16'h0000, 16'hFFFF, 16'hFFFF,
                            16'h5555, 16'h0FF0, 16'h9876,
                            16'h0001, 16'h0002, 16'h0001};
   logic [15:0] t_r [9] = '{16'h0000, 16'hFFFF, 16'hFFFE,
                            16'hFFFF, 16'h4CB3, 16'hAAAA,
                            16'h7FFF, 16'hFFFF, 16'h8000};
   logic t_s [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
   logic t_c [9] = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
   logic t_o [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 1};

   // {ovf, cout, sum[31:0]} from integer arithmetic on w-bit values
   function automatic logic [33:0] model(input int w,
         input logic [31:0] x, input logic [31:0] y, input logic s);
      longint mask, sx, sy, r, full, lim;
      logic [33:0] res;
      mask = (longint'(1) << w) - 1;
      lim  = longint'(1) << (w - 1);
      sx = longint'(x) & mask;
      sy = longint'(y) & mask;
      if (sx >= lim) sx = sx - (longint'(1) << w);
      if (sy >= lim) sy = sy - (longint'(1) << w);
      r = s ? sx - sy : sx + sy;
      full = (longint'(x) & mask)
           + (s ? ((~longint'(y)) & mask) + 1 : (longint'(y) & mask));
      res = '0;
      res[31:0] = 32'(r & mask);
      res[32] = ((full >> w) & 1) != 0;
      res[33] = (r < -lim) || (r >= lim);
      return res;
   endfunction

   task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                        input logic s, output int lat);
      int k;
      k = 0;
      while (!in_ready && k < 20) begin
         @(posedge clock); #1; k++;
      end
      a = x; b = y; sub = s; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clock); #1; lat++;
      end
   endtask

   task automatic release_op;
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   task automatic vop(input int k, input logic [31:0] x,
         input logic [31:0] y, input logic s, output logic [31:0] r,
         output logic c, output logic o, output int lat);
      int n;
      n = 0;
      while (!v_in_ready[k] && n < 20) begin
         @(posedge clock); #1; n++;
      end
      v_a[k] = x; v_b[k] = y; v_sub[k] = s; v_in_valid[k] = 1'b1;
      @(posedge clock); #1;
      v_in_valid[k] = 1'b0;
      lat = 0;
      while (!v_out_valid[k] && lat < 40) begin
         @(posedge clock); #1; lat++;
      end
      r = (k == 0) ? w_sum0 : {16'h0000, w_sum1};
      c = v_cout[k];
      o = v_ovf[k];
      v_out_ready[k] = 1'b1;
      @(posedge clock); #1;
      v_out_ready[k] = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clock);
      #1;
      for (int p = 0; p < 2; p++) begin
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset in_ready: got %b want 1", in_ready);
         end
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset out_valid: got %b want 0", out_valid);
         end
         n_cmp++;
         if ({sum, cout, ovf} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset outputs: got %h/%b/%b want 0",
                     sum, cout, ovf);
         end
         n_cmp++;
         if (v_out_valid !== 2'b00 || v_in_ready !== 2'b11) begin
            n_bad++;
            $display("FAIL reset variants: got %b/%b want 00/11",
                     v_out_valid, v_in_ready);
         end
         if (p == 0) begin
            reset_n = 1'b1;
            @(posedge clock); #1;
         end
      end
   endtask

   task automatic test_add_sweep;
      int lat;
      for (int i = 0; i < 6; i++) begin
         do_op(t_a[i], t_b[i], t_s[i], lat);
         n_cmp++;
         if (sum !== t_r[i]) begin
            n_bad++;
            $display("FAIL sweep[%0d] sum: got %h want %h",
                     i, sum, t_r[i]);
         end
         n_cmp++;
         if (cout !== t_c[i] || ovf !== t_o[i]) begin
            n_bad++;
            $display("FAIL sweep[%0d] cout/ovf: got %b/%b want %b/%b",
                     i, cout, ovf, t_c[i], t_o[i]);
         end
         n_cmp++;
         if (lat !== 4) begin
            n_bad++;
            $display("FAIL sweep[%0d] latency: got %0d want 4", i, lat);
         end
         release_op();
      end
   endtask

   task automatic test_sub_ovf;
      int lat;
      for (int i = 6; i < 9; i++) begin
         do_op(t_a[i], t_b[i], t_s[i], lat);
         n_cmp++;
         if (sum !== t_r[i]) begin
            n_bad++;
            $display("FAIL subovf[%0d] sum: got %h want %h",
                     i, sum, t_r[i]);
         end
         n_cmp++;
         if (cout !== t_c[i] || ovf !== t_o[i]) begin
            n_bad++;
            $display("FAIL subovf[%0d] cout/ovf: got %b/%b want %b/%b",
                     i, cout, ovf, t_c[i], t_o[i]);
         end
         n_cmp++;
         if (lat !== 4) begin
            n_bad++;
            $display("FAIL subovf[%0d] latency: got %0d want 4", i, lat);
         end
         release_op();
      end
   endtask

   task automatic test_random;
      logic [15:0] x, y;
      logic        s;
      logic [33:0] e;
      int          lat;
      for (int i = 0; i < 30; i++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         s = 1'($urandom_range(0, 1));
         e = model(16, {16'h0, x}, {16'h0, y}, s);
         do_op(x, y, s, lat);
         n_cmp++;
         if ({ovf, cout, sum} !== {e[33:32], e[15:0]} || lat !== 4) begin
            n_bad++;
            $display("FAIL random %h %s %h: got %h c%b v%b lat%0d want %h c%b v%b lat4",
                     x, s ? "-" : "+", y, sum, cout, ovf, lat,
                     e[15:0], e[32], e[33]);
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock); #1;
         end
         release_op();
      end
   endtask

   task automatic test_handshake;
      logic [15:0] x, y;
      logic        s;
      logic [33:0] e;
      int          lat;
      x = 16'($urandom);
      y = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      e = model(16, {16'h0, x}, {16'h0, y}, s);
      a = x; b = y; sub = s; in_valid = 1'b1;
      @(posedge clock); #1;
      lat = 0;
      repeat (3) begin
         in_valid  = 1'($urandom_range(0, 1));
         a         = 16'($urandom);
         b         = 16'($urandom);
         sub       = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clock); #1; lat++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      while (!out_valid && lat < 40) begin
         @(posedge clock); #1; lat++;
      end
      n_cmp++;
      if ({ovf, cout, sum} !== {e[33:32], e[15:0]} || lat !== 4) begin
         n_bad++;
         $display("FAIL hs result: got %h c%b v%b lat%0d want %h c%b v%b lat4",
                  sum, cout, ovf, lat, e[15:0], e[32], e[33]);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hs hold[%0d] valid/ready: got %b/%b want 1/0",
                     i, out_valid, in_ready);
         end
         n_cmp++;
         if (sum !== e[15:0] || cout !== e[32] || ovf !== e[33]) begin
            n_bad++;
            $display("FAIL hs hold[%0d] result: got %h want %h",
                     i, sum, e[15:0]);
         end
      end
      release_op();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL hs release ready/valid: got %b/%b want 1/0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      a = 16'h1234; b = 16'h9876; sub = 1'b0; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clock); #1;
      end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL midreset valid/ready: got %b/%b want 0/1",
                  out_valid, in_ready);
      end
      n_cmp++;
      if (sum !== 16'h0000) begin
         n_bad++;
         $display("FAIL midreset sum: got %h want 0000", sum);
      end
      #3 reset_n = 1'b1;
      @(posedge clock); #1;
      do_op(16'h0001, 16'h0001, 1'b0, lat);
      n_cmp++;
      if (sum !== 16'h0002 || lat !== 4) begin
         n_bad++;
         $display("FAIL midreset next op: got %h lat%0d want 0002 lat4",
                  sum, lat);
      end
      release_op();
   endtask

   task automatic test_params;
      logic [31:0] r, x, y;
      logic        c, o, s;
      logic [33:0] e;
      int          lat;
      vop(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, r, c, o, lat);
      n_cmp++;
      if (r !== 32'h0 || c !== 1'b1 || o !== 1'b0 || lat !== 4) begin
         n_bad++;
         $display("FAIL w32 wrap: got %h c%b v%b lat%0d want 0 c1 v0 lat4",
                  r, c, o, lat);
      end
      vop(1, 32'h1234, 32'h9876, 1'b0, r, c, o, lat);
      n_cmp++;
      if (r !== 32'hAAAA || c !== 1'b0 || o !== 1'b0 || lat !== 1) begin
         n_bad++;
         $display("FAIL c16 add: got %h c%b v%b lat%0d want aaaa c0 v0 lat1",
                  r, c, o, lat);
      end
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 10; i++) begin
            x = $urandom;
            y = $urandom;
            if (k == 1) begin
               x[31:16] = 16'h0;
               y[31:16] = 16'h0;
            end
            s = 1'($urandom_range(0, 1));
            e = model(k == 0 ? 32 : 16, x, y, s);
            vop(k, x, y, s, r, c, o, lat);
            n_cmp++;
            if (r !== e[31:0] || c !== e[32] || o !== e[33]
                || lat !== (k == 0 ? 4 : 1)) begin
               n_bad++;
               $display("FAIL variant%0d %h %s %h: got %h c%b v%b lat%0d want %h c%b v%b",
                        k, x, s ? "-" : "+", y, r, c, o, lat,
                        e[31:0], e[32], e[33]);
            end
         end
      end
   endtask

   initial begin
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      sub = 1'b0;
      v_in_valid = '0;
      v_out_ready = '0;
      v_sub = '0;
      v_a[0] = '0; v_a[1] = '0;
      v_b[0] = '0; v_b[1] = '0;
      test_reset();
      test_add_sweep();
      test_sub_ovf();
      test_random();
      test_handshake();
      test_reset_mid();
      test_params();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/add_serial.md
Name: add_serial

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the 16-bit combinational Add16.
- Processes a WIDTH-bit operation CHUNK bits per clock, rippling the carry through a register between chunks.
- Uses valid/ready handshakes on input and output, so it can sit between sequential datapath stages (ALU back end, accumulators).
- Trades latency for a short carry chain.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits added per clock. WIDTH must be an integer multiple of CHUNK; CHUNK = WIDTH is legal (single-chunk).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and sub are presented
- in_ready  output  1  block idle and able to accept
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- sub  input  1  0 = a+b, 1 = a-b; sampled on accept
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- N = WIDTH/CHUNK. Internal registers: state, operand A, operand B' (B, or ~B when sub), carry, chunk index (ceil(log2 N) bits, minimum 1), sum.
- Reset (reset_n low, asynchronous): state IDLE; carry, index, sum, cout, ovf and out_valid all 0; in_ready 1 once in IDLE.
- Reset asserted mid-operation aborts the operation. No result is produced; no partial state is kept.
- States:
  - IDLE: in_ready = 1, out_valid = 0. On an edge with in_valid=1:
    - latch a into A, and b (or ~b if sub) into B';
    - carry <= sub; index <= 0; sum <= 0;
    - go to RUN.
  - RUN: in_ready = 0, out_valid = 0. Each edge:
    - compute {c, s} = A[idx chunk] + B'[idx chunk] + carry;
    - write s into sum[idx chunk]; carry <= c; index++.
    - On the edge processing chunk N-1: cout <= c; ovf <= (A[MSB] == B'[MSB]) && (s[MSB of chunk] != A[MSB]); go to DONE.
  - DONE: out_valid = 1. sum, cout and ovf are stable and held until the handshake. On an edge with out_ready=1, go to IDLE.
- Latency: if the accept edge is edge 0, out_valid rises after edge N (N cycles). For WIDTH=16, CHUNK=4 this is 4 cycles.
- Throughput: one operation per N+2 cycles at best. There is no overlap and no input/output bypass; in_ready is low in RUN and DONE.
- Inputs a, b and sub are don't-care outside IDLE. Changing them during RUN has no effect.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Arithmetic:
  - sum == (a + b) mod 2^WIDTH, or (a - b) mod 2^WIDTH;
  - cout == bit WIDTH of a + B' + sub;
  - ovf per the signed-overflow rule above.
- outputs sum, cout and ovf are meaningful only while out_valid=1. Between operations they retain their last value until the next accept clears sum.
- Backpressure: DONE may be held indefinitely; the result must not change while waiting.

Test Plan:
- Add sweep, WIDTH=16, CHUNK=4, sub=0, each with out_ready=1:
  - 0000+0000 -> sum 0000, cout 0, ovf 0;
  - 0000+FFFF -> FFFF, 0, 0;
  - FFFF+FFFF -> FFFE, 1, 0;
  - AAAA+5555 -> FFFF, 0, 0;
  - 3CC3+0FF0 -> 4CB3, 0, 0;
  - 1234+9876 -> AAAA, 0, 0;
  - each with out_valid rising exactly 4 cycles after accept.
- Subtract and overflow:
  - 8000-0001 -> sum 7FFF, cout 1, ovf 1;
  - 0001-0002 -> FFFF, cout 0, ovf 0;
  - 7FFF+0001 -> 8000, cout 0, ovf 1.
- Handshake: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, sum stable, in_ready 0. Pulse out_ready -> IDLE next cycle, in_ready 1. Toggling in_valid/a/b during RUN does not affect the result.
- Reset mid-RUN: pull reset_n low asynchronously after chunk 2 of 1234+9876 -> out_valid 0, sum 0000 immediately. After release, a new op 0001+0001 -> 0002 with normal 4-cycle latency.
- Parameter variants:
  - WIDTH=32, CHUNK=8: FFFFFFFF+00000001 -> 00000000, cout 1, latency 4.
  - WIDTH=16, CHUNK=16: 1234+9876 -> AAAA, latency 1.
